// File: rtl/simon_pkg.sv
// Simon 32/64 shared constants, FSM state type and the key-schedule mix.
// Imported by key_step, key_gen_rev and key_gen.
package simon_pkg;

  localparam int N      = 16;
  localparam int M      = 4;
  localparam int ROUNDS = 32;

  localparam logic [N-1:0] C = 16'hFFFC;

  // MSB holds z[0]
  localparam logic [61:0] Z0 =
    62'b11111010001001010110000111001101111101000100101011000011100110;

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    EMIT,
    DONE
  } state_t;

  typedef enum logic {
    DIR_FWD,
    DIR_REV
  } dir_t;

  function automatic logic [N-1:0] simon_mix(
    input logic [N-1:0] a,
    input logic [N-1:0] b
  );
    logic [N-1:0] t;
    t = {a[2:0], a[N-1:3]} ^ b;
    return t ^ {t[0], t[N-1:1]};
  endfunction

  function automatic logic z_bit(input logic [4:0] i);
    logic [5:0] idx;
    idx = 6'd61 - {1'b0, i};
    return Z0[idx];
  endfunction

endpackage

// File: rtl/key_step.sv
// One key-schedule step, forward (new k[i+4]) or reverse (old k[i]).
// Ports: w0..w3 window (oldest first), z bit, dir; knew = computed word.
module key_step
  import simon_pkg::*;
(
  input  logic [N-1:0] w0,
  input  logic [N-1:0] w1,
  input  logic [N-1:0] w2,
  input  logic [N-1:0] w3,
  input  logic         z,
  input  dir_t         dir,
  output logic [N-1:0] knew
);

  logic [N-1:0] zw;

  assign zw = {{(N-1){1'b0}}, z};

  always_comb begin
    knew = '0;
    unique case (dir)
      DIR_FWD: knew = w0 ^ C ^ zw ^ simon_mix(w3, w1);
      DIR_REV: knew = w3 ^ C ^ zw ^ simon_mix(w2, w0);
      default: knew = '0;
    endcase
  end

endmodule

// File: rtl/key_gen_rev.sv
// Simon 32/64 reverse-order round-key generator: runs k0..k31 forward,
// then emits k31..k0 on ready/key_valid handshakes.
// Ports: clk, reset (async, active-low), start, key[63:0], ready;
// round_key, round_idx, key_valid, busy, done.
module key_gen_rev
  import simon_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [63:0]  key,
  input  logic         ready,
  output logic [N-1:0] round_key,
  output logic [4:0]   round_idx,
  output logic         key_valid,
  output logic         busy,
  output logic         done
);

  state_t       state, state_n;
  logic [N-1:0] w0, w1, w2, w3;
  logic [N-1:0] w0_n, w1_n, w2_n, w3_n;
  logic [4:0]   cnt, cnt_n;
  logic [4:0]   zi;
  dir_t         dir;
  logic [N-1:0] knew;

  // reverse step at index cnt recovers k[cnt-4]
  assign zi  = (state == FWD) ? cnt : cnt - 5'd4;
  assign dir = (state == FWD) ? DIR_FWD : DIR_REV;

  key_step u_step (
    .w0   (w0),
    .w1   (w1),
    .w2   (w2),
    .w3   (w3),
    .z    (z_bit(zi)),
    .dir  (dir),
    .knew (knew)
  );

  always_comb begin
    state_n = state;
    w0_n    = w0;
    w1_n    = w1;
    w2_n    = w2;
    w3_n    = w3;
    cnt_n   = cnt;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          w0_n    = key[15:0];
          w1_n    = key[31:16];
          w2_n    = key[47:32];
          w3_n    = key[63:48];
          cnt_n   = '0;
          state_n = FWD;
        end
      end
      FWD: begin
        w0_n  = w1;
        w1_n  = w2;
        w2_n  = w3;
        w3_n  = knew;
        cnt_n = cnt + 5'd1;
        if (cnt == 5'd27) begin
          cnt_n   = 5'd31;
          state_n = EMIT;
        end
      end
      EMIT: begin
        if (ready) begin
          if (cnt == 5'd0) begin
            state_n = DONE;
          end else begin
            // below idx 4 the older keys are already in the window
            w0_n  = (cnt >= 5'd4) ? knew : '0;
            w1_n  = w0;
            w2_n  = w1;
            w3_n  = w2;
            cnt_n = cnt - 5'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      w0    <= '0;
      w1    <= '0;
      w2    <= '0;
      w3    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      w0    <= w0_n;
      w1    <= w1_n;
      w2    <= w2_n;
      w3    <= w3_n;
      cnt   <= cnt_n;
    end
  end

  assign round_key = w3;
  assign round_idx = cnt;
  assign key_valid = (state == EMIT);
  assign busy      = (state == FWD) || (state == EMIT);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_key_gen_rev.sv
// Self-checking bench for key_gen_rev: array-based Simon key schedule
// reference, Simon decryption of the emitted keys, handshake corner cases.
module tb_key_gen_rev;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [63:0] key = '0;
  logic        ready = 1'b0;
  logic [15:0] round_key;
  logic [4:0]  round_idx;
  logic        key_valid;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [15:0] rk  [32];
  logic [15:0] got [32];

  localparam logic [61:0] ZSEQ =
    62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [63:0] KNOWN = 64'h1918111009080100;

  typedef struct {
    logic [63:0] key;
    int          pct;
    bit          glitch;
    bit          stall4;
    bit          has_ct;
    logic [31:0] ct;
    logic [31:0] pt;
  } vec_t;

  vec_t vecs [6];

  key_gen_rev dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .key       (key),
    .ready     (ready),
    .round_key (round_key),
    .round_idx (round_idx),
    .key_valid (key_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ror(input logic [15:0] x, input int r);
    return (x >> r) | (x << (16 - r));
  endfunction

  // textbook Simon 32/64 schedule: k[i] = ~k[i-4] ^ t ^ z ^ 3
  task automatic model(input logic [63:0] k);
    logic [15:0] t;
    for (int i = 0; i < 4; i++) rk[i] = k[16*i +: 16];
    for (int i = 4; i < 32; i++) begin
      t = ror(rk[i-1], 3) ^ rk[i-3];
      t = t ^ ror(t, 1);
      rk[i] = ~rk[i-4] ^ t ^ {15'd0, ZSEQ[65-i]} ^ 16'h0003;
    end
  endtask

  function automatic logic [15:0] f(input logic [15:0] x);
    return (ror(x, 15) & ror(x, 8)) ^ ror(x, 14);
  endfunction

  function automatic logic [31:0] decrypt(input logic [31:0] ct);
    logic [15:0] x, y, nx;
    x = ct[31:16];
    y = ct[15:0];
    for (int i = 31; i >= 0; i--) begin
      nx = y;
      y  = x ^ f(y) ^ got[i];
      x  = nx;
    end
    return {x, y};
  endfunction

  task automatic run(input vec_t v);
    int e, n, stall, guard;
    bit gl_emit;
    model(v.key);
    @(negedge clk);
    key   = v.key;
    start = 1'b1;
    ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("done_cleared", done, 0);
    n = 0;
    while (!key_valid && n < 100) begin
      if (v.glitch && n == 10) begin
        key   = '1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    chk("valid_latency", n, 28);
    e = 31;
    stall = 0;
    guard = 0;
    gl_emit = 0;
    while (e >= 0 && guard < 3000) begin
      @(negedge clk);
      guard++;
      start = 1'b0;
      chk("emit_valid", key_valid, 1);
      chk("emit_idx", round_idx, e);
      chk("emit_key", round_key, rk[e]);
      if (v.glitch && e == 20 && !gl_emit) begin
        start   = 1'b1;
        gl_emit = 1;
      end
      if (v.stall4 && e == 4 && stall < 10) begin
        ready = 1'b0;
        stall++;
      end else begin
        ready = ($urandom_range(99) < v.pct);
      end
      if (ready) begin
        got[e] = round_key;
        e--;
      end
    end
    checks++;
    if (e >= 0) begin
      errors++;
      $display("FAIL emit_timeout got idx %0d want -1", e);
    end
    @(negedge clk);
    start = 1'b0;
    ready = 1'b0;
    chk("done_set", done, 1);
    chk("done_valid_low", key_valid, 0);
    chk("done_busy_low", busy, 0);
    chk("done_key_k0", round_key, rk[0]);
    repeat (3) @(negedge clk);
    chk("done_held", done, 1);
    if (v.has_ct) chk("decrypt", decrypt(v.ct), v.pt);
  endtask

  task automatic reset_mid_emit();
    int n;
    model(KNOWN);
    @(negedge clk);
    key   = KNOWN;
    start = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(key_valid && round_idx == 5'd17) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach_idx17", round_idx, 17);
    reset = 1'b0;
    #1;
    chk("rst_valid", key_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_key", round_key, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_no_emit", {key_valid, busy, done}, 0);
  endtask

  initial begin
    vec_t rv;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_key", round_key, 0);
    chk("reset_idx", round_idx, 0);
    chk("reset_valid", key_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    reset = 1'b1;
    @(negedge clk);

    vecs[0] = '{key: KNOWN, pct: 100, glitch: 0, stall4: 0,
                has_ct: 1, ct: 32'hC69BE9BB, pt: 32'h65656877};
    vecs[1] = '{key: KNOWN, pct: 100, glitch: 1, stall4: 0,
                has_ct: 1, ct: 32'hC69BE9BB, pt: 32'h65656877};
    vecs[2] = '{key: KNOWN, pct: 50, glitch: 0, stall4: 1,
                has_ct: 1, ct: 32'hC69BE9BB, pt: 32'h65656877};
    vecs[3] = '{key: 64'h0, pct: 70, glitch: 0, stall4: 0,
                has_ct: 0, ct: 32'h0, pt: 32'h0};
    vecs[4] = '{key: '1, pct: 100, glitch: 1, stall4: 0,
                has_ct: 0, ct: 32'h0, pt: 32'h0};
    vecs[5] = '{key: {$urandom, $urandom}, pct: 40, glitch: 0, stall4: 1,
                has_ct: 0, ct: 32'h0, pt: 32'h0};

    for (int i = 0; i < 6; i++) run(vecs[i]);

    for (int i = 0; i < 4; i++) begin
      rv = '{key: {$urandom, $urandom}, pct: 30 + 20 * i, glitch: 1,
             stall4: 0, has_ct: 0, ct: 32'h0, pt: 32'h0};
      run(rv);
    end

    reset_mid_emit();
    run(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
